fetch_queue: RTL and testbench

Parametrised instruction prefetch unit that sits between instruction memory and the processor's controller/datapath, replacing the direct single-instruction fetch path. It issues sequential fetches over a request/grant memory handshake, buffers up to DEPTH instructions together with their addresses, and hands them to decode through a valid/ready interface. It also tracks the previously consumed instruction for multi-byte decode, and supports pipeline flush/redirect with in-flight stale responses discarded.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_queue_fifo_sync.sv | 58 +++++
 rtl/fetch_queue.sv | 114 +++++++++++
 tb/tb_fetch_queue.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
//   Shared helpers for the instruction prefetch unit and its FIFO.
//   No ports; provides the counter-width helper used to size occupancy
//   and credit counters that must hold the range 0..DEPTH inclusive.
package fetch_queue_pkg;

    // Bits needed to hold any value 0..depth (depth is a power of two).
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_fifo_sync.sv
// fifo_sync
//   Synchronous FIFO with push, pop and single-cycle flush. DEPTH must be a
//   power of two so the read/write pointers wrap naturally.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push, push_data write one entry
//   pop             drop the head entry
//   flush           empty the FIFO (wins over push/pop)
//   head            oldest entry (undefined when empty)
//   count           number of stored entries, 0..DEPTH
//   empty, full     occupancy flags
module fifo_sync
    import fetch_queue_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             head,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic                         empty,
    output logic                         full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction prefetch unit between instruction memory and decode. Issues
//   sequential fetches over a req/gnt handshake, buffers up to DEPTH
//   {instruction, address} pairs and presents them through valid/ready.
//   Redirect flushes the queue and restarts fetch; responses still in
//   flight at that moment are counted and discarded when they return.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   imem_addr/imem_req/imem_gnt      fetch request channel
//   imem_rvalid/imem_rdata           in-order fetch responses
//   redirect/redirect_pc             flush and restart at a new address
//   instr_valid/instr_ready          decode handshake on the head entry
//   instr/instr_pc                   head instruction and its address
//   prev_instr                       last instruction consumed by decode
`ifndef FETCH_QUEUE
`define FETCH_QUEUE
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                 ADDR_W   = 16,
    parameter int                 INSTR_W  = 8,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_req,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [INSTR_W-1:0] prev_instr
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0]         fetch_pc;
    logic [ADDR_W-1:0]         resp_pc;
    logic [CNT_W-1:0]          outstanding;
    logic [CNT_W-1:0]          discard;
    logic [CNT_W-1:0]          count;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [INSTR_W+ADDR_W-1:0] head;
    logic [SUM_W-1:0]          credit_used;
    logic                      transfer;
    logic                      drop;
    logic                      push;
    logic                      pop;

    // Every issued request reserves a queue slot until it is consumed, so
    // a returning response can never find the queue full.
    assign credit_used = SUM_W'(count) + SUM_W'(outstanding);
    assign imem_req    = !reset && !redirect && (credit_used < SUM_W'(DEPTH));
    assign transfer    = imem_req && imem_gnt;
    assign imem_addr   = fetch_pc;

    assign drop = imem_rvalid && (discard != '0);
    assign push = imem_rvalid && !drop && !redirect && (!fifo_full || pop);

    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready && !redirect;
    assign instr       = instr_valid ? head[ADDR_W +: INSTR_W] : '0;
    assign instr_pc    = instr_valid ? head[ADDR_W-1:0]        : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            prev_instr  <= '0;
        end else if (redirect) begin
            // Everything still in flight is stale; a response landing in
            // this very cycle is dropped here and so is not counted again.
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            outstanding <= outstanding - CNT_W'(imem_rvalid);
            discard     <= outstanding - CNT_W'(imem_rvalid);
            prev_instr  <= '0;
        end else begin
            if (transfer) fetch_pc <= fetch_pc + ADDR_W'(1);
            if (push)     resp_pc  <= resp_pc + ADDR_W'(1);
            outstanding <= outstanding + CNT_W'(transfer) - CNT_W'(imem_rvalid);
            if (drop)     discard  <= discard - CNT_W'(1);
            if (pop)      prev_instr <= instr;
        end
    end

    fifo_sync #(
        .WIDTH (INSTR_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({imem_rdata, resp_pc}),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
`endif

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Randomized bench for fetch_queue. The bench plays instruction memory
//   (in-order responses with random latency) and tracks each request as a
//   transaction that is either live or stale, plus a queue of delivered
//   instructions, and compares all DUT outputs every cycle.
module tb_fetch_queue;

    localparam int ADDR_W = 16;
    localparam int INSTR_W = 8;
    localparam int DEPTH = 4;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
    localparam int N_CYC = 1701;

    logic               clk = 1'b0;
    logic               reset;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_req;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic [INSTR_W-1:0] prev_instr;

    fetch_queue #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .prev_instr  (prev_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        bit                stale;
        int                rdy;
    } txn_t;

    typedef struct {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] ins;
    } entry_t;

    txn_t   inflight[$];
    entry_t q[$];
    logic [ADDR_W-1:0]  m_fetch_pc;
    logic [INSTR_W-1:0] m_prev;
    int                 last_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Memory contents: a function of the address so wrong-address
    // deliveries are visible.
    function automatic logic [INSTR_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    initial begin
        bit   rst_v, redir_v, rdy_v, gnt_v, rv, req_e, valid_e, xfer;
        int   lat_max, lat, r;
        logic [ADDR_W-1:0] rpc;
        txn_t t;

        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        inflight.delete(); q.delete();
        m_fetch_pc = RESET_PC; m_prev = '0; last_rdy = 0;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            rst_v = (cyc < 3) || (cyc >= 1511 && cyc < 1513);
            redir_v = 1'b0; rpc = '0;
            if ((cyc >= 3 && cyc <= 202) || cyc >= 1513) begin
                rdy_v = 1'b1; gnt_v = 1'b1; lat_max = 0;
            end else if (cyc >= 203 && cyc <= 240) begin
                rdy_v = 1'b0; gnt_v = 1'b1; lat_max = 0;
            end else if (cyc >= 241 && cyc <= 280) begin
                rdy_v = 1'b1; gnt_v = 1'b1; lat_max = 0;
            end else if (cyc >= 1500 && cyc <= 1510) begin
                rdy_v = 1'b0; gnt_v = 1'b1; lat_max = 3;
            end else begin
                rdy_v = ($urandom_range(0, 9) < 7);
                gnt_v = ($urandom_range(0, 9) < 7);
                lat_max = 3;
                r = $urandom_range(0, 11);
                if (cyc == 700) begin
                    redir_v = 1'b1; rpc = 16'hFFFE;
                end else if (r == 0) begin
                    redir_v = 1'b1;
                    case ($urandom_range(0, 2))
                        0: rpc = 16'h0100;
                        1: rpc = 16'hFFFD;
                        default: rpc = ADDR_W'($urandom);
                    endcase
                end
            end
            if (rst_v) redir_v = 1'b0;

            rv = !rst_v && (inflight.size() > 0) && (inflight[0].rdy <= cyc);
            reset       = rst_v;
            redirect    = redir_v;
            redirect_pc = rpc;
            instr_ready = rdy_v;
            imem_gnt    = gnt_v;
            imem_rvalid = rv;
            imem_rdata  = rv ? mem_data(inflight[0].addr) : INSTR_W'($urandom);
            #1;

            if (rst_v) begin
                check_eq("req_in_reset", {31'b0, imem_req}, 32'd0);
                q.delete(); inflight.delete();
                m_fetch_pc = RESET_PC; m_prev = '0; last_rdy = 0;
                continue;
            end

            req_e   = !redir_v && ((q.size() + inflight.size()) < DEPTH);
            valid_e = (q.size() > 0);
            check_eq("imem_req",    {31'b0, imem_req}, {31'b0, req_e});
            check_eq("imem_addr",   {16'b0, imem_addr}, {16'b0, m_fetch_pc});
            check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, valid_e});
            check_eq("instr",       {24'b0, instr}, valid_e ? {24'b0, q[0].ins} : 32'd0);
            check_eq("instr_pc",    {16'b0, instr_pc}, valid_e ? {16'b0, q[0].pc} : 32'd0);
            check_eq("prev_instr",  {24'b0, prev_instr}, {24'b0, m_prev});
            if ((cyc >= 5 && cyc <= 202) || cyc >= 1515)
                check_eq("throughput", {31'b0, instr_valid}, 32'd1);

            xfer = req_e && gnt_v;
            if (redir_v) begin
                if (rv) void'(inflight.pop_front());
                foreach (inflight[k]) inflight[k].stale = 1'b1;
                q.delete();
                m_fetch_pc = rpc;
                m_prev = '0;
            end else begin
                if (valid_e && rdy_v) begin
                    m_prev = q[0].ins;
                    void'(q.pop_front());
                end
                if (rv) begin
                    t = inflight.pop_front();
                    if (!t.stale) q.push_back('{pc: t.addr, ins: mem_data(t.addr)});
                end
                if (xfer) begin
                    lat = $urandom_range(0, lat_max);
                    t.addr  = m_fetch_pc;
                    t.stale = 1'b0;
                    t.rdy   = (cyc + 1 + lat > last_rdy + 1) ? cyc + 1 + lat : last_rdy + 1;
                    last_rdy = t.rdy;
                    inflight.push_back(t);
                    m_fetch_pc = m_fetch_pc + ADDR_W'(1);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
